// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: register-address/control fields coming from the
// pipeline registers and the stall/flush/forward controls going back to them.
// The master side is the pipeline datapath, the slave side is hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0] rs1D_i;
  logic [4:0] rs2D_i;
  logic [4:0] rs1E_i;
  logic [4:0] rs2E_i;
  logic [4:0] rdE_i;
  logic [1:0] result_srcE_i;
  logic       pc_srcE_i;
  logic [4:0] rdM_i;
  logic       reg_writeM_i;
  logic       mem_reqM_i;
  logic [4:0] rdW_i;
  logic       reg_writeW_i;

  logic       stallF_o;
  logic       stallD_o;
  logic       flushD_o;
  logic       stallE_o;
  logic       flushE_o;
  logic       stallM_o;
  logic       flushW_o;
  logic [1:0] forward_aE_o;
  logic [1:0] forward_bE_o;
  logic       busy_o;

  modport master (
    output rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, result_srcE_i, pc_srcE_i,
           rdM_i, reg_writeM_i, mem_reqM_i, rdW_i, reg_writeW_i,
    input  stallF_o, stallD_o, flushD_o, stallE_o, flushE_o, stallM_o,
           flushW_o, forward_aE_o, forward_bE_o, busy_o
  );

  modport slave (
    input  rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, result_srcE_i, pc_srcE_i,
           rdM_i, reg_writeM_i, mem_reqM_i, rdW_i, reg_writeW_i,
    output stallF_o, stallD_o, flushD_o, stallE_o, flushE_o, stallM_o,
           flushW_o, forward_aE_o, forward_bE_o, busy_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Produces stall/flush enables for the F/D/E/M/W pipeline registers, the
// E-stage forwarding selects, and sequences fixed-latency data-memory waits.
// Optional build macro HAZARD_PERF_EN adds stall/branch-flush event counters.
module hazard_ctrl #(
  parameter int unsigned MEM_WAIT_CYCLES = 0,
  parameter int unsigned CNT_WIDTH       = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic                 MEM_WAIT_EN = (MEM_WAIT_CYCLES != 0);
  // The IDLE cycle that accepts the request is itself a stall cycle, so the
  // counter is loaded with one less than the total wait.
  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD   =
    (MEM_WAIT_CYCLES != 0) ? CNT_WIDTH'(MEM_WAIT_CYCLES - 1) : '0;

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 mem_stall;
  logic                 lw_stall;

  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       stall_e;
  logic       flush_e;
  logic       stall_m;
  logic       flush_w;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       busy;

  // M-stage result has priority over W; x0 is hardwired zero and never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Memory-wait state register and counter, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic for the memory wait sequencer and the resulting stall.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_stall  = 1'b0;
    unique case (state)
      INIT: begin
        state_next = IDLE;
      end
      IDLE: begin
        if (hz.mem_reqM_i && MEM_WAIT_EN) begin
          state_next = WAIT;
          cnt_next   = WAIT_LOAD;
          mem_stall  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          mem_stall = 1'b1;
          cnt_next  = cnt - CNT_WIDTH'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // Load-use detection: a load in E whose destination is read by the op in D.
  always_comb begin
    lw_stall = (hz.result_srcE_i == 2'b01) && (hz.rdE_i != 5'd0) &&
               ((hz.rdE_i == hz.rs1D_i) || (hz.rdE_i == hz.rs2D_i));
  end

  // Output priority: reset, INIT, memory stall, redirect, load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    stall_e = 1'b0;
    flush_e = 1'b0;
    stall_m = 1'b0;
    flush_w = 1'b0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    busy    = 1'b0;
    if (!rst_ni) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      fwd_a = fwd_sel(hz.rs1E_i, hz.rdM_i, hz.reg_writeM_i, hz.rdW_i, hz.reg_writeW_i);
      fwd_b = fwd_sel(hz.rs2E_i, hz.rdM_i, hz.reg_writeM_i, hz.rdW_i, hz.reg_writeW_i);
      busy  = (state == WAIT);
      if (state == INIT) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (mem_stall) begin
        // E is frozen, so branch and load-use decisions are simply re-made
        // once the wait releases.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz.pc_srcE_i) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign hz.stallF_o     = stall_f;
  assign hz.stallD_o     = stall_d;
  assign hz.flushD_o     = flush_d;
  assign hz.stallE_o     = stall_e;
  assign hz.flushE_o     = flush_e;
  assign hz.stallM_o     = stall_m;
  assign hz.flushW_o     = flush_w;
  assign hz.forward_aE_o = fwd_a;
  assign hz.forward_bE_o = fwd_b;
  assign hz.busy_o       = busy;

`ifdef HAZARD_PERF_EN
  logic branch_flush;

  // A redirect flush counts only when it actually wins the priority chain.
  always_comb begin
    branch_flush = rst_ni && (state != INIT) && !mem_stall && hz.pc_srcE_i;
  end

  // Free-running event counters, cleared by reset and wrapping naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_f) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (branch_flush) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl with MEM_WAIT_CYCLES=3.
// Expected output vectors are queued as stimulus is driven; a negedge monitor
// pops and compares them. Vector bit order:
// {stallF, stallD, flushD, stallE, flushE, stallM, flushW, fwdA[1:0], fwdB[1:0], busy}
module tb_hazard_ctrl;

  logic clk_i;
  logic rst_ni;

  int compared;
  int mismatched;

  logic [11:0] exp_q[$];
  string       name_q[$];

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  hazard_ctrl #(
    .MEM_WAIT_CYCLES(3),
    .CNT_WIDTH(4)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .hz    (hz.slave)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [11:0] pat(input int sF, input int sD, input int fD,
                                      input int sE, input int fE, input int sM,
                                      input int fW, input int fa, input int fb,
                                      input int busy);
    return {1'(sF), 1'(sD), 1'(fD), 1'(sE), 1'(fE), 1'(sM), 1'(fW),
            2'(fa), 2'(fb), 1'(busy)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, advance one clock.
  task automatic applyStimulus(input string name, input int rstn,
                               input int rs1D, input int rs2D, input int rs1E,
                               input int rs2E, input int rdE, input int rsrc,
                               input int pcs, input int rdM, input int rwM,
                               input int mreq, input int rdW, input int rwW,
                               input logic [11:0] exp);
    rst_ni              = 1'(rstn);
    hz.rs1D_i           = 5'(rs1D);
    hz.rs2D_i           = 5'(rs2D);
    hz.rs1E_i           = 5'(rs1E);
    hz.rs2E_i           = 5'(rs2E);
    hz.rdE_i            = 5'(rdE);
    hz.result_srcE_i    = 2'(rsrc);
    hz.pc_srcE_i        = 1'(pcs);
    hz.rdM_i            = 5'(rdM);
    hz.reg_writeM_i     = 1'(rwM);
    hz.mem_reqM_i       = 1'(mreq);
    hz.rdW_i            = 5'(rdW);
    hz.reg_writeW_i     = 1'(rwW);
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk_i) begin
    logic [11:0] got;
    logic [11:0] exp;
    string       nm;
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {hz.stallF_o, hz.stallD_o, hz.flushD_o, hz.stallE_o, hz.flushE_o,
             hz.stallM_o, hz.flushW_o, hz.forward_aE_o, hz.forward_bE_o,
             hz.busy_o};
      checkOutput(nm, 32'(got), 32'(exp));
    end
  end

  initial begin
    logic [11:0] RST;
    logic [11:0] STL;
    logic [11:0] STLB;
    logic [11:0] QUIET;
    compared   = 0;
    mismatched = 0;
    RST   = pat(0,0,1,0,1,0,0,0,0,0);
    STL   = pat(1,1,0,1,0,1,1,0,0,0);
    STLB  = pat(1,1,0,1,0,1,1,0,0,1);
    QUIET = pat(0,0,0,0,0,0,0,0,0,0);

    rst_ni = 1'b0;
    hz.rs1D_i = '0; hz.rs2D_i = '0; hz.rs1E_i = '0; hz.rs2E_i = '0;
    hz.rdE_i = '0; hz.result_srcE_i = '0; hz.pc_srcE_i = 1'b0;
    hz.rdM_i = '0; hz.reg_writeM_i = 1'b0; hz.mem_reqM_i = 1'b0;
    hz.rdW_i = '0; hz.reg_writeW_i = 1'b0;
    @(posedge clk_i);
    #1;

    //            name         rst rs1D rs2D rs1E rs2E rdE src pc rdM wM mq rdW wW
    applyStimulus("rst1",       0,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, RST);
    applyStimulus("rst2",       0,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, RST);
    applyStimulus("rst3_force", 0,  0,   0,   5,   0,   0,  0, 1,  5, 1, 1,  0, 0, RST);
    applyStimulus("init",       1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, RST);
    applyStimulus("idle",       1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, QUIET);

    applyStimulus("fwd_m_prio", 1,  0,   0,   5,   0,   0,  0, 0,  5, 1, 0,  5, 1, pat(0,0,0,0,0,0,0,2,0,0));
    applyStimulus("fwd_w",      1,  0,   0,   5,   0,   0,  0, 0,  0, 1, 0,  5, 1, pat(0,0,0,0,0,0,0,1,0,0));
    applyStimulus("fwd_x0",     1,  0,   0,   0,   0,   0,  0, 0,  0, 1, 0,  0, 1, QUIET);
    applyStimulus("fwd_we_off", 1,  0,   0,   9,   9,   0,  0, 0,  9, 0, 0,  9, 1, pat(0,0,0,0,0,0,0,1,1,0));
    applyStimulus("fwd_split",  1,  0,   0,   3,   4,   0,  0, 0,  4, 1, 0,  3, 1, pat(0,0,0,0,0,0,0,1,2,0));

    applyStimulus("lw_use",     1,  0,   7,   0,   0,   7,  1, 0,  0, 0, 0,  0, 0, pat(1,1,0,0,1,0,0,0,0,0));
    applyStimulus("lw_notload", 1,  0,   7,   0,   0,   7,  2, 0,  0, 0, 0,  0, 0, QUIET);
    applyStimulus("lw_x0",      1,  0,   0,   0,   0,   0,  1, 0,  0, 0, 0,  0, 0, QUIET);
    applyStimulus("lw_vs_br",   1,  7,   0,   0,   0,   7,  1, 1,  0, 0, 0,  0, 0, pat(0,0,1,0,1,0,0,0,0,0));
    applyStimulus("branch",     1,  0,   0,   0,   0,   0,  0, 1,  0, 0, 0,  0, 0, pat(0,0,1,0,1,0,0,0,0,0));

    applyStimulus("mem_start",  1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 1,  0, 0, STL);
    applyStimulus("mem_w1_br",  1,  0,   0,   0,   0,   0,  0, 1,  0, 0, 0,  0, 0, STLB);
    applyStimulus("mem_w2_br",  1,  7,   0,   0,   0,   7,  1, 1,  0, 0, 1,  0, 0, STLB);
    applyStimulus("mem_rel_br", 1,  0,   0,   0,   0,   0,  0, 1,  0, 0, 0,  0, 0, pat(0,0,1,0,1,0,0,0,0,1));
    applyStimulus("mem_idle",   1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, QUIET);

    applyStimulus("b2b_start",  1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 1,  0, 0, STL);
    applyStimulus("b2b_w1",     1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 1,  0, 0, STLB);
    applyStimulus("b2b_w2",     1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 1,  0, 0, STLB);
    applyStimulus("b2b_rel",    1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 1,  0, 0, pat(0,0,0,0,0,0,0,0,0,1));
    applyStimulus("b2b_retrig", 1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 1,  0, 0, STL);
    applyStimulus("mid_rst",    0,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, RST);
    applyStimulus("mid_init",   1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, RST);
    applyStimulus("re_start",   1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 1,  0, 0, STL);
    applyStimulus("re_w1",      1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, STLB);
    applyStimulus("re_w2",      1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, STLB);
    applyStimulus("re_rel",     1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, pat(0,0,0,0,0,0,0,0,0,1));
    applyStimulus("re_idle",    1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, QUIET);

    // Event-count sequence: 3-cycle wait, one load-use, two taken branches.
    applyStimulus("pf_rst",     0,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, RST);
    applyStimulus("pf_init",    1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, RST);
    applyStimulus("pf_mem",     1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 1,  0, 0, STL);
    applyStimulus("pf_w1",      1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, STLB);
    applyStimulus("pf_w2",      1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, STLB);
    applyStimulus("pf_rel",     1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, pat(0,0,0,0,0,0,0,0,0,1));
    applyStimulus("pf_lw",      1,  4,   0,   0,   0,   4,  1, 0,  0, 0, 0,  0, 0, pat(1,1,0,0,1,0,0,0,0,0));
    applyStimulus("pf_br1",     1,  0,   0,   0,   0,   0,  0, 1,  0, 0, 0,  0, 0, pat(0,0,1,0,1,0,0,0,0,0));
    applyStimulus("pf_br2",     1,  0,   0,   0,   0,   0,  0, 1,  0, 0, 0,  0, 0, pat(0,0,1,0,1,0,0,0,0,0));
    applyStimulus("pf_idle",    1,  0,   0,   0,   0,   0,  0, 0,  0, 0, 0,  0, 0, QUIET);

`ifdef HAZARD_PERF_EN
    checkOutput("stall_cnt", stall_cnt, 32'd4);
    checkOutput("flush_cnt", flush_cnt, 32'd2);
`endif

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
      @(negedge clk_i);
    end
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
